// File: rtl/muldiv_if.sv
// Request/response bundle between a register-file controller and the
// iterative multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  dst;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        wen;
  logic [3:0]  selr;
  logic        divz;

  modport master (
    output start, op, a, b, dst,
    input  busy, done, result, wen, selr, divz
  );

  modport slave (
    input  start, op, a, b, dst,
    output busy, done, result, wen, selr, divz
  );
endinterface

// File: rtl/muldiv_unit.sv
// Sequential unsigned 16-bit MUL/MULH/DIV/REM unit: one bit per cycle,
// 16 iterations, with a result write-back pulse to the register file.
module muldiv_unit (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic [15:0] a_reg, b_reg;
  logic [1:0]  op_reg;
  logic [3:0]  selr_reg;
  logic [31:0] acc_reg;
  logic [15:0] result_reg;
  logic        divz_reg;

  logic        last_iter;
  logic        b_zero;
  logic [31:0] mul_step;
  logic [16:0] div_trial;
  logic [16:0] div_diff;
  logic [31:0] div_step;
  logic [31:0] acc_next;
  logic [15:0] result_next;

  assign last_iter = (cnt_reg == 5'd15);
  assign b_zero    = (b_reg == 16'h0000);

  // MUL walks the multiplier MSB first: shift the accumulator, add A on a set bit.
  assign mul_step = {acc_reg[30:0], 1'b0} + (b_reg[4'd15 - cnt_reg[3:0]] ? {16'h0000, a_reg} : 32'h0);

  // DIV keeps remainder in acc[31:16] and shifts dividend/quotient through acc[15:0].
  assign div_trial = acc_reg[31:15];
  assign div_diff  = div_trial - {1'b0, b_reg};
  assign div_step  = (div_trial >= {1'b0, b_reg}) ? {div_diff[15:0], acc_reg[14:0], 1'b1}
                                                  : {div_trial[15:0], acc_reg[14:0], 1'b0};

  assign acc_next = op_reg[1] ? div_step : mul_step;

  always_comb begin
    result_next = 16'h0000;
    case (op_reg)
      2'b00: result_next = acc_next[15:0];
      2'b01: result_next = acc_next[31:16];
      2'b10: result_next = b_zero ? 16'hFFFF : acc_next[15:0];
      2'b11: result_next = b_zero ? a_reg : acc_next[31:16];
      default: result_next = 16'h0000;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start) state_next = RUN;
      RUN:  if (last_iter) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 5'd0;
      a_reg      <= 16'h0000;
      b_reg      <= 16'h0000;
      op_reg     <= 2'b00;
      selr_reg   <= 4'h0;
      acc_reg    <= 32'h0;
      result_reg <= 16'h0000;
      divz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            op_reg   <= bus.op;
            selr_reg <= bus.dst;
            cnt_reg  <= 5'd0;
            acc_reg  <= bus.op[1] ? {16'h0000, bus.a} : 32'h0;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 5'd1;
          if (last_iter) begin
            result_reg <= result_next;
            divz_reg   <= op_reg[1] & b_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = (state_reg == DONE);
  assign bus.wen    = (state_reg == DONE) & ~divz_reg;
  assign bus.result = result_reg;
  assign bus.selr   = selr_reg;
  assign bus.divz   = divz_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: latency, results, flags, and the
// ignored-start and reset-abort sequences.
module tb_muldiv_unit;
  logic clk;
  logic rst;
  muldiv_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  dst;
    logic [15:0] res;
    logic        dz;
    logic        wen;
  } vec_t;

  vec_t vecs [10];
  int checks;
  int failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Accept one operation, verify 16 quiet cycles, the DONE cycle, then return to idle.
  task automatic run_vec(input vec_t v);
    int early;
    @(negedge clk);
    bus.start = 1'b1; bus.op = v.op; bus.a = v.a; bus.b = v.b; bus.dst = v.dst;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'h5A5A; bus.b = 16'hA5A5; bus.dst = 4'hF;
    check({v.name, " busy_after_accept"}, {31'b0, bus.busy}, 32'd1);
    early = 0;
    for (int k = 0; k < 16; k++) begin
      if (bus.done || bus.wen) early++;
      @(negedge clk);
    end
    check({v.name, " early_done"}, early, 0);
    $display("%s op=%0d a=0x%04h b=0x%04h -> result=0x%04h divz=%0b wen=%0b done=%0b selr=0x%0h",
             v.name, v.op, v.a, v.b, bus.result, bus.divz, bus.wen, bus.done, bus.selr);
    check({v.name, " done"},   {31'b0, bus.done}, 32'd1);
    check({v.name, " wen"},    {31'b0, bus.wen},  {31'b0, v.wen});
    check({v.name, " result"}, {16'b0, bus.result}, {16'b0, v.res});
    check({v.name, " divz"},   {31'b0, bus.divz}, {31'b0, v.dz});
    check({v.name, " selr"},   {28'b0, bus.selr}, {28'b0, v.dst});
    @(negedge clk);
    check({v.name, " idle_after"}, {30'b0, bus.busy, bus.done}, 32'd0);
    check({v.name, " result_hold"}, {16'b0, bus.result}, {16'b0, v.res});
  endtask

  initial begin
    int ndone;
    int spur;
    logic [15:0] seen_res;
    logic [3:0]  seen_sel;
    checks = 0;
    failures = 0;

    vecs[0] = '{"mul_basic",  2'b00, 16'h0123, 16'h0010, 4'h5, 16'h1230, 1'b0, 1'b1};
    vecs[1] = '{"mulh_max",   2'b01, 16'hFFFF, 16'hFFFF, 4'h1, 16'hFFFE, 1'b0, 1'b1};
    vecs[2] = '{"mul_max",    2'b00, 16'hFFFF, 16'hFFFF, 4'h2, 16'h0001, 1'b0, 1'b1};
    vecs[3] = '{"div_100_7",  2'b10, 16'd100,  16'd7,    4'h3, 16'h000E, 1'b0, 1'b1};
    vecs[4] = '{"rem_100_7",  2'b11, 16'd100,  16'd7,    4'h4, 16'h0002, 1'b0, 1'b1};
    vecs[5] = '{"div_zero",   2'b10, 16'h1234, 16'h0000, 4'h6, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{"rem_zero",   2'b11, 16'h1234, 16'h0000, 4'h7, 16'h1234, 1'b1, 1'b0};
    vecs[7] = '{"mulh_mixed", 2'b01, 16'h1234, 16'h5678, 4'h8, 16'h0626, 1'b0, 1'b1};
    vecs[8] = '{"div_by_one", 2'b10, 16'hFFFF, 16'h0001, 4'h9, 16'hFFFF, 1'b0, 1'b1};
    vecs[9] = '{"rem_4096_7", 2'b11, 16'h1000, 16'h0007, 4'hA, 16'h0001, 1'b0, 1'b1};

    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 16'h0; bus.b = 16'h0; bus.dst = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {bus.busy, bus.done, bus.wen, bus.divz, bus.selr, bus.result},
          {4'b0, 4'h0, 16'h0000});
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // A second start during RUN must not disturb the operation in flight.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h0123; bus.b = 16'h0010; bus.dst = 4'h5;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0; seen_res = 16'h0; seen_sel = 4'h0;
    for (int k = 0; k < 24; k++) begin
      if (k == 3) begin
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 16'hAAAA; bus.b = 16'h0003; bus.dst = 4'h9;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        seen_res = bus.result;
        seen_sel = bus.selr;
      end
      @(negedge clk);
    end
    $display("ignored_start: done_pulses=%0d result=0x%04h selr=0x%0h", ndone, seen_res, seen_sel);
    check("ignored_start done_count", ndone, 1);
    check("ignored_start result", {16'b0, seen_res}, 32'h1230);
    check("ignored_start selr", {28'b0, seen_sel}, 32'h5);

    // Reset during iteration 8 aborts silently; a start sampled with rst is dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.dst = 4'hC;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    $display("reset_abort: busy=%0b result=0x%04h selr=0x%0h", bus.busy, bus.result, bus.selr);
    check("abort busy", {31'b0, bus.busy}, 32'd0);
    check("abort result", {16'b0, bus.result}, 32'h0);
    check("abort selr", {28'b0, bus.selr}, 32'h0);
    spur = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done || bus.wen || bus.busy) spur++;
      @(negedge clk);
    end
    check("abort quiet", spur, 0);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; data width fixed at 16 bits, register index width fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only when busy=0.
REQ-005 op  input  2  operation: 00 MUL (product low 16), 01 MULH (product high 16, unsigned), 10 DIV (unsigned quotient), 11 REM (unsigned remainder).
REQ-006 a  input  16  operand A, driven from the register file A read port.
REQ-007 b  input  16  operand B, driven from the register file B read port.
REQ-008 dst  input  4  destination register index for the result.
REQ-009 busy  output  1  high while an operation is in progress (RUN or DONE state).
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  16  operation result, driven onto the register file write bus.
REQ-012 wen  output  1  register file write enable, one-cycle pulse.
REQ-013 selR  output  4  register file write select; equals the latched dst.
REQ-014 divz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-015 The unit SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-016 IDLE: on an edge with start=1, the unit SHALL latch a, b, op, and dst, clear the iteration counter, and enter RUN.
REQ-017 start SHALL be ignored in RUN and DONE; latched operands SHALL NOT change until the next acceptance.
REQ-018 RUN: the unit SHALL perform exactly one iteration per cycle for 16 cycles, counted with a 5-bit counter 0..15.
- MUL/MULH: shift-add over a 32-bit accumulator.
- DIV/REM: restoring division, one quotient bit per cycle, MSB first.
REQ-019 On the edge completing iteration 15 the FSM SHALL enter DONE, so that with acceptance at edge N, DONE holds during the cycle after edge N+16.
REQ-020 DONE: done=1, result valid, selR=latched dst, and wen=1 unless divz=1; the next edge SHALL return to IDLE.
REQ-021 busy SHALL equal 1 in RUN and DONE and 0 in IDLE.
REQ-022 A new start SHALL be accepted no earlier than the edge following DONE (back-to-back throughput of 18 cycles per operation).
REQ-023 Arithmetic SHALL be unsigned.
- MUL: result = (A*B)[15:0].
- MULH: result = (A*B)[31:16].
- DIV: result = A/B.
- REM: result = A mod B.
REQ-024 Divide by zero (op=1x, B=0): the unit SHALL take the same 16-cycle latency, set divz=1, produce result=0xFFFF for DIV and result=A for REM, and assert wen=0 in DONE (done still pulses).
REQ-025 divz SHALL be 0 for MUL and MULH operations; divz and result SHALL hold their last completed values until the next completion.
REQ-026 selR SHALL hold the latched dst from acceptance until the next acceptance.
REQ-027 wen and done SHALL be 0 in IDLE and RUN.

Reset
REQ-028 When rst=1 at an edge, the unit SHALL enter IDLE and clear all outputs to 0: busy, done, wen, divz, result=0x0000, selR=0x0.
REQ-029 rst SHALL take priority over start and abort any in-progress operation with no done or wen pulse.
REQ-030 start sampled in the same edge as rst=1 SHALL be discarded.

Verification
REQ-031 MUL, a=0x0123, b=0x0010, dst=0x5, accepted at edge N -> done=wen=1 in the cycle after edge N+16 only, result=0x1230, selR=0x5, divz=0.
REQ-032 MULH and MUL with a=0xFFFF, b=0xFFFF -> MULH result=0xFFFE; MUL result=0x0001; each has a 16-cycle latency.
REQ-033 DIV 100/7 -> result=0x000E; REM 100/7 -> result=0x0002; wen=1 for both.
REQ-034 DIV, a=0x1234, b=0 -> result=0xFFFF, divz=1, done=1, wen=0; REM, a=0x1234, b=0 -> result=0x1234, divz=1, wen=0.
REQ-035 Second start with different operands pulsed during RUN -> ignored; the first result is unchanged and only one done pulse occurs.
REQ-036 rst=1 asserted at iteration 8 of a MUL -> busy=0 and result=0x0000 on the next cycle; no done or wen follows; a fresh start afterward completes correctly.
